// File: rtl/clk_div_sel_ctrl_pkg.sv
// Shared types and constants for the clock-divider ratio controller.
package clk_div_pkg;

  localparam int CNT_W_DEF = 4;

  // Ratio select encoding: select s divides by 2^(s+1)
  localparam int SEL_DIV2  = 0;
  localparam int SEL_DIV4  = 1;
  localparam int SEL_DIV8  = 2;
  localparam int SEL_DIV16 = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

endpackage

// File: rtl/clk_div_sel_ctrl_if.sv
// Request handshake and divided-clock outputs of the ratio controller.
// With CLK_DIV_ALL_OUT_EN defined the bus also carries the fixed div_all taps.
interface clk_div_sel_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = $clog2(CNT_W)
) ();

  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_ready;
  logic [SEL_W-1:0] cur_sel;
  logic             div_clk;
  logic             div_en;
  logic             busy;
  logic             switch_done;
`ifdef CLK_DIV_ALL_OUT_EN
  logic [CNT_W-1:0] div_all;

  modport master (
    output req_valid, req_sel,
    input  req_ready, cur_sel, div_clk, div_en, busy, switch_done, div_all
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, cur_sel, div_clk, div_en, busy, switch_done, div_all
  );
`else
  modport master (
    output req_valid, req_sel,
    input  req_ready, cur_sel, div_clk, div_en, busy, switch_done
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, cur_sel, div_clk, div_en, busy, switch_done
  );
`endif

endinterface

// File: rtl/clk_div_sel_ctrl_counter.sv
// Free-running divide counter with end-of-period detect for two runtime selects.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = $clog2(CNT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [SEL_W-1:0] i_sel_cur,
  input  logic [SEL_W-1:0] i_sel_sw,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc_cur,
  output logic             o_tc_sw
);

  logic [CNT_W-1:0] r_count;
  logic             w_tc_cur;
  logic             w_tc_sw;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // tc(s): count[s:0] all ones, i.e. last cycle of a 2^(s+1) period
  always_comb begin
    w_tc_cur = 1'b1;
    w_tc_sw  = 1'b1;
    for (int i = 0; i < CNT_W; i++) begin
      if (i <= int'(i_sel_cur) && !r_count[i]) w_tc_cur = 1'b0;
      if (i <= int'(i_sel_sw)  && !r_count[i]) w_tc_sw  = 1'b0;
    end
  end

  assign o_count  = r_count;
  assign o_tc_cur = w_tc_cur;
  assign o_tc_sw  = w_tc_sw;

endmodule

// File: rtl/clk_div_sel_ctrl.sv
// Run-time power-of-two divide-ratio controller; ratio changes land on a shared period boundary.
// Optional macro CLK_DIV_ALL_OUT_EN adds the registered fixed-ratio taps bus.div_all.
module clk_div_sel_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SEL_W         = $clog2(CNT_W),
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  clk_div_sel_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_cur_sel;
  logic [SEL_W-1:0] r_pend_sel;
  logic [SEL_W-1:0] w_req_sel_clamp;
  logic [SEL_W-1:0] w_sw_sel;
  logic [3:0]       r_settle;
  logic             r_div_clk;
  logic             r_div_en;
  logic             r_done;
  logic             w_accept;
  logic             w_switch;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_count;
  logic             w_tc_cur;
  logic             w_tc_sw;

  always_comb begin
    w_req_sel_clamp = bus.req_sel;
    if (int'(bus.req_sel) >= CNT_W) w_req_sel_clamp = SEL_W'(CNT_W - 1);
  end

  // The slower of old and new ratio ends its period only where the faster one does too
  assign w_sw_sel = (r_pend_sel > r_cur_sel) ? r_pend_sel : r_cur_sel;

  clk_div_counter #(
    .CNT_W(CNT_W),
    .SEL_W(SEL_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_switch),
    .i_sel_cur(r_cur_sel),
    .i_sel_sw (w_sw_sel),
    .o_count  (w_count),
    .o_tc_cur (w_tc_cur),
    .o_tc_sw  (w_tc_sw)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_switch    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (w_req_sel_clamp == r_cur_sel) w_done_nxt  = 1'b1;
          else                              w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_tc_sw) begin
          w_switch    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle == 4'd0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output stage: divided clock and enable follow count by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_sel  <= SEL_W'(SEL_DIV2);
      r_pend_sel <= '0;
      r_settle   <= '0;
      r_div_clk  <= 1'b0;
      r_div_en   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_div_clk <= w_count[r_cur_sel];
      r_div_en  <= w_tc_cur;
      r_done    <= w_done_nxt;
      if (w_accept) r_pend_sel <= w_req_sel_clamp;
      if (w_switch) begin
        r_cur_sel <= r_pend_sel;
        r_settle  <= 4'(SETTLE_CYCLES - 1);
      end else if (r_state == ST_SETTLE && r_settle != 4'd0) begin
        r_settle <= r_settle - 4'd1;
      end
    end
  end

  assign bus.req_ready   = (r_state == ST_IDLE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.cur_sel     = r_cur_sel;
  assign bus.div_clk     = r_div_clk;
  assign bus.div_en      = r_div_en;
  assign bus.switch_done = r_done;

`ifdef CLK_DIV_ALL_OUT_EN
  logic [CNT_W-1:0] r_div_all;

  always_ff @(posedge clk) begin
    if (rst) r_div_all <= '0;
    else     r_div_all <= w_count;
  end

  assign bus.div_all = r_div_all;
`endif

endmodule

// File: tb/tb_clk_div_sel_ctrl.sv
// Self-checking bench for clk_div_sel_ctrl: directed corner sequences, a vector table
// and randomized requests against a period-arithmetic reference model.
module tb_clk_div_sel_ctrl;
  import clk_div_pkg::*;

  localparam int CNT_W   = 4;
  localparam int SETTLE  = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk;
  logic rst;

  clk_div_sel_if #(.CNT_W(CNT_W)) bus ();

  clk_div_sel_ctrl #(
    .CNT_W        (CNT_W),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: values visible after the most recent posedge
  int m_cyc = 0;
  int m_cnt, m_cur, m_pend, m_all;
  int m_sw_edge = -1;
  int m_done_edge = -1;
  bit m_busy, m_dclk, m_den, m_done, m_acc;
  bit m_live = 1'b0;

  typedef struct {
    int         idle;
    logic [1:0] sel;
    logic [1:0] exp_cur;
  } vec_t;

  vec_t tbl[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model works from period arithmetic: a switch lands on the first edge where the
  // count sits at the last cycle of the longer of the two periods.
  task automatic mdl_step();
    int cnt_old, cur_old, s, m, span, j;
    bit busy_old;
    m_cyc++;
    m_acc = 1'b0;
    if (rst) begin
      m_live = 1'b1;
      m_cnt = 0; m_cur = 0; m_pend = 0; m_all = 0;
      m_busy = 0; m_dclk = 0; m_den = 0; m_done = 0;
      m_sw_edge = -1; m_done_edge = -1;
    end else begin
      cnt_old  = m_cnt;
      cur_old  = m_cur;
      busy_old = m_busy;
      span     = 2 << cur_old;
      m_dclk   = ((cnt_old >> cur_old) & 1) != 0;
      m_den    = ((cnt_old + 1) % span) == 0;
      m_all    = cnt_old;
      m_done   = (m_cyc == m_done_edge);
      if (m_cyc == m_sw_edge) begin
        m_cur = m_pend;
        m_cnt = 0;
      end else begin
        m_cnt = (cnt_old + 1) % CNT_MOD;
      end
      if (m_cyc == m_done_edge) m_busy = 0;
      if (!busy_old && bus.req_valid === 1'b1) begin
        m_acc = 1'b1;
        s = int'(bus.req_sel);
        if (s >= CNT_W) s = CNT_W - 1;
        if (s == cur_old) begin
          m_done = 1'b1;
        end else begin
          m_pend = s;
          m = (s > cur_old) ? s : cur_old;
          span = 2 << m;
          j = span - 1 - (cnt_old % span);
          if (j == 0) j = span;
          m_sw_edge   = m_cyc + j;
          m_done_edge = m_sw_edge + SETTLE;
          m_busy      = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    mdl_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("ready",   bus.req_ready,   !m_busy);
      chk("busy",    bus.busy,        m_busy);
      chk("cur_sel", bus.cur_sel,     m_cur);
      chk("div_clk", bus.div_clk,     m_dclk);
      chk("div_en",  bus.div_en,      m_den);
      chk("done",    bus.switch_done, m_done);
`ifdef CLK_DIV_ALL_OUT_EN
      chk("div_all", bus.div_all,     m_all);
`endif
    end
  end

  task automatic wait_cnt(input int v);
    int k = 0;
    while (m_cnt != v && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wait_cnt_bound", k < 40, 1);
  endtask

  task automatic do_req(input logic [1:0] sel);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    while (!m_acc && k < 80) begin
      @(negedge clk);
      k++;
    end
    bus.req_valid = 1'b0;
    chk("req_accepted", m_acc, 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (bus.switch_done !== 1'b1 && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", bus.switch_done, 1);
  endtask

  initial begin
    int   n, nd, na, cnt_a, cnt_b;
    bit   got;
    logic dc[18];
    logic de[18];
    logic dn[18];

    tbl[0] = '{2, 2'(SEL_DIV16), 2'd3};
    tbl[1] = '{0, 2'(SEL_DIV2),  2'd0};
    tbl[2] = '{4, 2'(SEL_DIV2),  2'd0};
    tbl[3] = '{1, 2'(SEL_DIV8),  2'd2};
    tbl[4] = '{7, 2'(SEL_DIV4),  2'd1};
    tbl[5] = '{0, 2'(SEL_DIV16), 2'd3};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;

    // Reset: three cycles, outputs idle with ready high
    repeat (3) @(negedge clk);
    chk("rst_ready",   bus.req_ready, 1);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_cur",     bus.cur_sel, 0);
    chk("rst_div_clk", bus.div_clk, 0);
    chk("rst_div_en",  bus.div_en, 0);
    chk("rst_done",    bus.switch_done, 0);
    rst = 1'b0;
    cnt_a = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.div_clk === logic'(i % 2 == 0) && bus.div_en === logic'(i % 2 == 0)) cnt_a++;
    end
    chk("div2_toggle", cnt_a, 8);

    // Up-switch /2 -> /16 requested at count 5
    wait_cnt(5);
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd3;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (m_acc) bus.req_valid = 1'b0;
      if (bus.cur_sel === 2'd3) got = 1;
    end
    chk("up_latency", n, 11);
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      dc[i] = bus.div_clk;
      dn[i] = bus.switch_done;
    end
    cnt_a = 0; cnt_b = 0; nd = -1;
    for (int i = 1; i <= 8; i++)  if (dc[i] === 1'b0) cnt_a++;
    for (int i = 9; i <= 16; i++) if (dc[i] === 1'b1) cnt_b++;
    for (int i = 17; i >= 0; i--) if (dn[i] === 1'b1) nd = i;
    chk("up_edge_high", dc[0], 1);
    chk("up_low8",  cnt_a, 8);
    chk("up_high8", cnt_b, 8);
    chk("up_done_lag", nd, 2);

    // Down-switch /16 -> /4 requested at count 2
    wait_cnt(2);
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd1;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (m_acc) bus.req_valid = 1'b0;
      if (bus.cur_sel === 2'd1) got = 1;
    end
    chk("down_latency", n, 14);
    cnt_a = 0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      de[i] = bus.div_en;
      if (de[i] === logic'(i % 4 == 0)) cnt_a++;
    end
    chk("down_en_every4", cnt_a, 17);

    // Same-ratio request: done after one cycle, never busy
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd1;
    @(negedge clk);
    chk("same_busy0", bus.busy, 0);
    bus.req_valid = 1'b0;
    chk("same_done1", bus.switch_done, 1);
    @(negedge clk);
    chk("same_done_pulse", bus.switch_done, 0);

    // Back-pressure: second request held through PENDING/SETTLE
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd2;
    n = 0;
    while (n < 40 && !m_acc) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first_acc", m_acc, 1);
    bus.req_sel = 2'd0;
    chk("bp_ready_low", bus.req_ready, 0);
    nd = -1; na = -1;
    for (int i = 1; i <= 80 && na < 0; i++) begin
      @(negedge clk);
      if (bus.switch_done === 1'b1 && nd < 0) nd = i;
      if (m_acc) begin
        na = i;
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    chk("bp_accept_after_done", na - nd, 1);
    wait_done();
    chk("bp_final_sel", bus.cur_sel, 0);

    // Reset while PENDING, request held across reset
    wait_cnt(1);
    do_req(2'd3);
    @(negedge clk);
    @(negedge clk);
    chk("rp_pending_busy", bus.busy, 1);
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rp_no_done", bus.switch_done, 0);
      chk("rp_cur0",    bus.cur_sel, 0);
      chk("rp_busy0",   bus.busy, 0);
`ifdef CLK_DIV_ALL_OUT_EN
      chk("rp_all_rst", bus.div_all, 0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rp_acc_first_cycle", bus.busy, 1);
`ifdef CLK_DIV_ALL_OUT_EN
    chk("rp_all0", bus.div_all, 0);
`endif
    bus.req_valid = 1'b0;
    @(negedge clk);
`ifdef CLK_DIV_ALL_OUT_EN
    chk("rp_all1", bus.div_all, 1);
`endif
    wait_done();
    chk("rp_final_sel", bus.cur_sel, 2);

    // Vector table
    for (int t = 0; t < 6; t++) begin
      repeat (tbl[t].idle) @(negedge clk);
      do_req(tbl[t].sel);
      wait_done();
      chk("tbl_cur_sel", bus.cur_sel, tbl[t].exp_cur);
    end

    // Randomized requests, gaps and occasional resets
    for (int r = 0; r < 250; r++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end
      do_req(2'($urandom_range(0, 3)));
    end
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
